avl_master_lsu: RTL and testbench

//  Avalon-MM master that turns single CPU load/store requests (byte/half/word,
//  any legal alignment) into word-aligned Avalon transactions with byteenable.

---
 rtl/avl_master_lsu.sv | 165 ++++++++++++++++
 tb/tb_avl_master_lsu.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/avl_master_lsu.sv
// Purpose: single-beat Avalon-MM master for CPU byte/half/word loads and stores.
// Latency: command from the cycle after accept; cpu_done the cycle after the completing edge.
// Backpressure: holds the command while avm_waitrequest=1; cpu_busy blocks new requests.
module avl_master_lsu #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic [31:0] avm_address,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  output logic        avm_read,
  output logic        avm_write,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // A zero TIMEOUT_CYCLES disables the stall watchdog entirely.
  localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [1:0]  lane_q, lane_nxt;
  logic [1:0]  size_q, size_nxt;
  logic        sgn_q, sgn_nxt;
  logic [31:0] to_cnt, to_cnt_nxt;
  logic        busy_nxt, done_nxt, err_nxt, rd_nxt, wr_nxt;
  logic [31:0] rdata_nxt, addr_nxt, wdat_nxt;
  logic [3:0]  be_nxt;
  logic        illegal;
  logic [31:0] lane_data;
  logic [31:0] load_val;

  // Request legality and load-lane extraction with sign/zero extension.
  always_comb begin
    illegal   = (cpu_size == 2'b11) ||
                (cpu_size == 2'b01 && cpu_addr[0]) ||
                (cpu_size == 2'b10 && cpu_addr[1:0] != 2'b00);
    lane_data = avm_readdata >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   load_val = {{24{sgn_q & lane_data[7]}}, lane_data[7:0]};
      2'b01:   load_val = {{16{sgn_q & lane_data[15]}}, lane_data[15:0]};
      default: load_val = lane_data;
    endcase
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt  = state;
    lane_nxt   = lane_q;
    size_nxt   = size_q;
    sgn_nxt    = sgn_q;
    to_cnt_nxt = to_cnt;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    rd_nxt     = avm_read;
    wr_nxt     = avm_write;
    rdata_nxt  = cpu_rdata;
    addr_nxt   = avm_address;
    be_nxt     = avm_byteenable;
    wdat_nxt   = avm_writedata;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (illegal) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
          end else begin
            state_nxt  = ACCESS;
            addr_nxt   = {cpu_addr[31:2], 2'b00};
            lane_nxt   = cpu_addr[1:0];
            size_nxt   = cpu_size;
            sgn_nxt    = cpu_signed;
            to_cnt_nxt = 32'd0;
            rd_nxt     = ~cpu_we;
            wr_nxt     = cpu_we;
            case (cpu_size)
              2'b00: begin
                be_nxt   = 4'b0001 << cpu_addr[1:0];
                wdat_nxt = {4{cpu_wdata[7:0]}};
              end
              2'b01: begin
                be_nxt   = 4'b0011 << cpu_addr[1:0];
                wdat_nxt = {2{cpu_wdata[15:0]}};
              end
              default: begin
                be_nxt   = 4'b1111;
                wdat_nxt = cpu_wdata;
              end
            endcase
          end
        end
      end
      ACCESS: begin
        if (!avm_waitrequest) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          if (avm_read) rdata_nxt = load_val;
        end else if (TO_EN && to_cnt == TO_LAST) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
        end else begin
          to_cnt_nxt = to_cnt + 32'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      lane_q         <= 2'b00;
      size_q         <= 2'b00;
      sgn_q          <= 1'b0;
      to_cnt         <= 32'd0;
      cpu_busy       <= 1'b0;
      cpu_done       <= 1'b0;
      cpu_err        <= 1'b0;
      cpu_rdata      <= 32'd0;
      avm_address    <= 32'd0;
      avm_byteenable <= 4'd0;
      avm_writedata  <= 32'd0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
    end else begin
      state          <= state_nxt;
      lane_q         <= lane_nxt;
      size_q         <= size_nxt;
      sgn_q          <= sgn_nxt;
      to_cnt         <= to_cnt_nxt;
      cpu_busy       <= busy_nxt;
      cpu_done       <= done_nxt;
      cpu_err        <= err_nxt;
      cpu_rdata      <= rdata_nxt;
      avm_address    <= addr_nxt;
      avm_byteenable <= be_nxt;
      avm_writedata  <= wdat_nxt;
      avm_read       <= rd_nxt;
      avm_write      <= wr_nxt;
    end
  end

endmodule

// File: tb/tb_avl_master_lsu.sv
// Bench for avl_master_lsu: directed cases plus randomized transactions
// checked against a byte-level reference model; a second instance with
// TIMEOUT_CYCLES=4 exercises the stall watchdog.
module tb_avl_master_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cpu_req, cpu_req_t, cpu_we, cpu_signed, avm_waitrequest;
  logic [31:0] cpu_addr, cpu_wdata, avm_readdata;
  logic [1:0]  cpu_size;

  logic        cpu_busy, cpu_done, cpu_err, avm_read, avm_write;
  logic [31:0] cpu_rdata, avm_address, avm_writedata;
  logic [3:0]  avm_byteenable;

  logic        busy_t, done_t, err_t, read_t, write_t;
  logic [31:0] rdata_t, address_t, writedata_t;
  logic [3:0]  byteenable_t;

  avl_master_lsu dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_size(cpu_size), .cpu_signed(cpu_signed), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata), .avm_read(avm_read), .avm_write(avm_write),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  avl_master_lsu #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .cpu_req(cpu_req_t), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_size(cpu_size), .cpu_signed(cpu_signed), .cpu_wdata(cpu_wdata),
    .cpu_busy(busy_t), .cpu_done(done_t), .cpu_err(err_t), .cpu_rdata(rdata_t),
    .avm_address(address_t), .avm_byteenable(byteenable_t),
    .avm_writedata(writedata_t), .avm_read(read_t), .avm_write(write_t),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  int          ntests = 0;
  int          nfail  = 0;
  logic [31:0] exp_rdata = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    ntests++;
    assert (obs === want) else begin
      nfail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, want);
    end
  endtask

  // Reference: access of nbytes at byte offset off within the word.
  function automatic void model(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output bit legal, output logic [3:0] be,
                                output logic [31:0] wdo, output logic [31:0] rdo);
    int nbytes, off;
    logic [31:0] mask, v;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off    = int'(a[1:0]);
    legal  = (sz != 2'd3) && ((off % nbytes) == 0);
    be     = 4'(((1 << nbytes) - 1) << off);
    for (int i = 0; i < 4; i++) wdo[8*i +: 8] = wd[8*(i % nbytes) +: 8];
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nbytes)) - 32'd1);
    v    = (rd >> (8*off)) & mask;
    if (sg && v[8*nbytes-1]) v = v | ~mask;
    rdo = v;
  endfunction

  // One request on the main instance; stall = waitrequest-high cycles before completion.
  task automatic txn(input logic [31:0] a, input logic [1:0] sz, input logic we,
                     input logic sg, input logic [31:0] wd, input logic [31:0] rd,
                     input int stall, input bit noisy);
    bit          legal;
    logic [3:0]  be;
    logic [31:0] wdo, rdo;
    model(a, sz, sg, wd, rd, legal, be, wdo, rdo);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_size = sz; cpu_signed = sg;
    cpu_wdata = wd; avm_waitrequest = 1'b1; avm_readdata = $urandom;
    @(negedge clk);
    cpu_req = 1'b0;
    if (!legal) begin
      chk("illegal_done", 32'(cpu_done), 32'd1);
      chk("illegal_err", 32'(cpu_err), 32'd1);
      chk("illegal_nobus", 32'({avm_read, avm_write}), 32'd0);
      chk("illegal_rdata", cpu_rdata, exp_rdata);
    end else begin
      chk("cmd_addr", avm_address, {a[31:2], 2'b00});
      chk("cmd_be", 32'(avm_byteenable), 32'(be));
      chk("cmd_wdata", avm_writedata, wdo);
      chk("cmd_rw", 32'({avm_read, avm_write}), 32'({~we, we}));
      chk("cmd_busy", 32'(cpu_busy), 32'd1);
      chk("cmd_nodone", 32'(cpu_done), 32'd0);
      for (int k = 0; k < stall; k++) begin
        avm_waitrequest = 1'b1;
        if (noisy) begin
          cpu_req = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
        end
        @(negedge clk);
        chk("stall_addr", avm_address, {a[31:2], 2'b00});
        chk("stall_be_wd", avm_writedata ^ 32'(avm_byteenable), wdo ^ 32'(be));
        chk("stall_rw", 32'({avm_read, avm_write, cpu_done}), 32'({~we, we, 1'b0}));
      end
      cpu_req = 1'b0; avm_waitrequest = 1'b0; avm_readdata = rd;
      @(negedge clk);
      avm_waitrequest = 1'b1; avm_readdata = $urandom;
      if (!we) exp_rdata = rdo;
      chk("done_pulse", 32'(cpu_done), 32'd1);
      chk("done_err", 32'(cpu_err), 32'd0);
      chk("done_rdata", cpu_rdata, exp_rdata);
      chk("done_rw", 32'({avm_read, avm_write}), 32'd0);
    end
    if (noisy) cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    chk("after_done", 32'(cpu_done), 32'd0);
    chk("after_busy", 32'(cpu_busy), 32'd0);
    chk("after_rw", 32'({avm_read, avm_write}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_req_t = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0;
    cpu_size = 2'd0; cpu_signed = 1'b0; cpu_wdata = 32'd0;
    avm_readdata = 32'd0; avm_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 32'({cpu_busy, cpu_done, cpu_err, avm_read, avm_write}), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_addr", avm_address, 32'd0);
    chk("rst_be_wd", avm_writedata | 32'(avm_byteenable), 32'd0);
    rst = 1'b0;

    // Directed cases.
    txn(32'hBFC0_0000, 2'd2, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 0, 1'b0);
    txn(32'h0000_0006, 2'd0, 1'b1, 1'b0, 32'h0000_00AB, 32'h0, 0, 1'b0);
    txn(32'h0000_0007, 2'd0, 1'b0, 1'b1, 32'h0, 32'h80FF_0000, 0, 1'b0);
    txn(32'h0000_0007, 2'd0, 1'b0, 1'b0, 32'h0, 32'h80FF_0000, 1, 1'b0);
    txn(32'h0000_0002, 2'd1, 1'b0, 1'b1, 32'h0, 32'h8001_1234, 2, 1'b0);
    txn(32'h0000_0001, 2'd1, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    txn(32'h0000_0000, 2'd3, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    txn(32'h0000_0102, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    txn(32'h0000_0040, 2'd2, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h0, 5, 1'b1);
    txn(32'h0000_0044, 2'd1, 1'b0, 1'b0, 32'h0, 32'h9876_5432, 5, 1'b1);
    txn(32'h0000_0048, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0BAD_BEEF, 10, 1'b0);

    // Randomized mix, mostly aligned.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = a[1:0] & ~(2'((1 << sz) - 1));
      txn(a, sz, 1'($urandom), 1'($urandom), $urandom, $urandom,
          int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Reset in the middle of an access.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_size = 2'd2; avm_waitrequest = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    chk("prerst_read", 32'(avm_read), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    exp_rdata = 32'd0;
    chk("rst_abandon", 32'({avm_read, avm_write, cpu_busy, cpu_done}), 32'd0);
    chk("rst_abandon_rdata", cpu_rdata, exp_rdata);
    rst = 1'b0; avm_waitrequest = 1'b0;
    @(negedge clk);
    chk("rst_nodone", 32'(cpu_done), 32'd0);

    // Watchdog on the TIMEOUT_CYCLES=4 instance with waitrequest stuck high.
    @(negedge clk);
    cpu_req_t = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20; cpu_size = 2'd2;
    avm_waitrequest = 1'b1; avm_readdata = 32'h5555_AAAA;
    @(negedge clk);
    cpu_req_t = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("to_stall", 32'({read_t, done_t}), 32'b10);
      @(negedge clk);
    end
    chk("to_done", 32'(done_t), 32'd1);
    chk("to_err", 32'(err_t), 32'd1);
    chk("to_read", 32'(read_t), 32'd0);
    chk("to_rdata", rdata_t, 32'd0);
    chk("to_main_idle", 32'(cpu_busy), 32'd0);
    @(negedge clk);
    chk("to_after", 32'({done_t, busy_t}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
